// File: rtl/axis_pfifo.sv
// Single-clock AXI-Stream store-and-forward packet FIFO: a frame becomes visible
// on the master side only once its tlast word is stored. Optional macro AXIS_PFIFO_DROP_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_WRITE | normal store; tlast word commits the frame
//   ST_DROP  | overflowed frame: every word accepted and discarded to tlast
module axis_pfifo #(
    parameter int WIDTH = 8,
    parameter int ABITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [WIDTH-1:0] m_tdata,
    output logic [ABITS:0]   level_o,
    output logic             drop_o
);

    localparam int PW    = ABITS + 1;
    localparam int DEPTH = 2 ** ABITS;

    typedef enum logic {
        ST_WRITE
`ifdef AXIS_PFIFO_DROP_EN
        , ST_DROP
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q, wr_tmp_q;
    logic [PW-1:0]  rd_ptr_d, wr_ptr_d, wr_tmp_d;
    logic [WIDTH:0] mem [DEPTH];
    logic           accept, full, wr_en, rd_fire, drop_d;

    assign level_o = wr_tmp_q - rd_ptr_q;
    // level never exceeds DEPTH, so its MSB alone flags full
    assign full    = level_o[ABITS];

`ifdef AXIS_PFIFO_DROP_EN
    assign s_tready = 1'b1;
    assign drop_o   = drop_d;
`else
    assign s_tready = ~full;
    assign drop_o   = 1'b0;
`endif

    assign accept   = s_tvalid & s_tready;
    assign m_tvalid = (rd_ptr_q != wr_ptr_q);
    assign {m_tlast, m_tdata} = mem[rd_ptr_q[ABITS-1:0]];
    assign rd_fire  = m_tvalid & m_tready;

    always_comb begin
        state_d  = state_q;
        wr_tmp_d = wr_tmp_q;
        wr_ptr_d = wr_ptr_q;
        wr_en    = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            ST_WRITE: begin
                if (accept) begin
`ifdef AXIS_PFIFO_DROP_EN
                    if (full) begin
                        // rewind to the commit point; committed frames stay intact
                        wr_tmp_d = wr_ptr_q;
                        if (s_tlast) drop_d  = 1'b1;
                        else         state_d = ST_DROP;
                    end else
`endif
                    begin
                        wr_en    = 1'b1;
                        wr_tmp_d = wr_tmp_q + PW'(1);
                        if (s_tlast) wr_ptr_d = wr_tmp_q + PW'(1);
                    end
                end
            end
`ifdef AXIS_PFIFO_DROP_EN
            ST_DROP: begin
                if (accept && s_tlast) begin
                    state_d = ST_WRITE;
                    drop_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_WRITE;
        endcase
    end

    assign rd_ptr_d = rd_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_WRITE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            wr_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            wr_tmp_q <= wr_tmp_d;
        end
    end

    // storage is deliberately not reset
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_tmp_q[ABITS-1:0]] <= {s_tlast, s_tdata};
    end

endmodule

// File: tb/tb_axis_pfifo.sv
// Directed self-checking bench for axis_pfifo (WIDTH=8, ABITS=4).
// Drop-mode scenarios compile in only when AXIS_PFIFO_DROP_EN is defined.
module tb_axis_pfifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       m_tvalid, m_tready = 1'b0, m_tlast;
    logic [7:0] m_tdata;
    logic [4:0] level_o;
    logic       drop_o;

    int vectors = 0;
    int miscompares = 0;

    axis_pfifo #(.WIDTH(8), .ABITS(4)) dut (
        .clock(clock), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
        .level_o(level_o), .drop_o(drop_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); end
        vectors++;
        if (level_o !== 5'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level_o); end
        vectors++;
        if (s_tready !== 1'b1) begin miscompares++; $display("FAIL reset_s_tready got %b want 1", s_tready); end
        vectors++;
        if (drop_o !== 1'b0) begin miscompares++; $display("FAIL reset_drop got %b want 0", drop_o); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] d [3];
        d = '{8'h11, 8'h22, 8'h33};
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1; s_tdata = d[i]; s_tlast = (i == 2);
            #1;
            vectors++;
            if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL frame_early_valid word %0d got %b want 0", i, m_tvalid); end
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (m_tvalid !== 1'b1 || m_tdata !== d[i] || m_tlast !== (i == 2))
                begin miscompares++; $display("FAIL frame_out word %0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, m_tvalid, m_tdata, m_tlast, d[i], (i == 2)); end
            vectors++;
            if (level_o !== 5'(3 - i)) begin miscompares++; $display("FAIL frame_level word %0d got %0d want %0d", i, level_o, 3 - i); end
            tick();
        end
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || level_o !== 5'd0)
            begin miscompares++; $display("FAIL frame_drained got v=%b lvl=%0d want v=0 lvl=0", m_tvalid, level_o); end
        m_tready = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1; s_tdata = i[7:0]; s_tlast = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        #1;
        vectors++;
        if (level_o !== 5'd16 || s_tready !== 1'b0)
            begin miscompares++; $display("FAIL full_state got lvl=%0d rdy=%b want lvl=16 rdy=0", level_o, s_tready); end
        vectors++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h00)
            begin miscompares++; $display("FAIL full_head got v=%b d=%h want v=1 d=00", m_tvalid, m_tdata); end
        vectors++;
        if (drop_o !== 1'b0) begin miscompares++; $display("FAIL full_drop got %b want 0", drop_o); end
        s_tvalid = 1'b1; s_tdata = 8'hEE;
        tick();
        s_tvalid = 1'b0;
        #1;
        vectors++;
        if (level_o !== 5'd16) begin miscompares++; $display("FAIL full_blocked_write got lvl=%0d want 16", level_o); end
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        #1;
        vectors++;
        if (s_tready !== 1'b1 || level_o !== 5'd15 || m_tdata !== 8'h01)
            begin miscompares++; $display("FAIL full_one_read got rdy=%b lvl=%0d d=%h want rdy=1 lvl=15 d=01", s_tready, level_o, m_tdata); end
        m_tready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            #1;
            vectors++;
            if (m_tvalid !== 1'b1 || m_tdata !== i[7:0] || m_tlast !== 1'b1)
                begin miscompares++; $display("FAIL full_drain word %0d got v=%b d=%h l=%b want v=1 d=%h l=1", i, m_tvalid, m_tdata, m_tlast, i[7:0]); end
            tick();
        end
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || level_o !== 5'd0)
            begin miscompares++; $display("FAIL full_empty got v=%b lvl=%0d want v=0 lvl=0", m_tvalid, level_o); end
        m_tready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [8:0]  q [$];
        logic [8:0]  exp_w;
        logic [15:0] lfsr;
        logic        stall_prev;
        logic [8:0]  held;
        int sent, got, cyc;
        do_reset();
        lfsr = 16'hACE1; sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        s_tvalid = 1'b1; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = lfsr[0];
        while (got < 400 && cyc < 4000) begin
            #1;
            if (stall_prev) begin
                vectors++;
                if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== held)
                    begin miscompares++; $display("FAIL b2b_hold cyc %0d got v=%b w=%h want v=1 w=%h", cyc, m_tvalid, {m_tlast, m_tdata}, held); end
            end
            if (s_tvalid && s_tready) begin
                q.push_back({s_tlast, s_tdata});
                sent++;
            end
            if (m_tvalid && m_tready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++; $display("FAIL b2b_spurious cyc %0d got w=%h want none", cyc, {m_tlast, m_tdata});
                end else begin
                    exp_w = q.pop_front();
                    if ({m_tlast, m_tdata} !== exp_w)
                        begin miscompares++; $display("FAIL b2b_data word %0d got %h want %h", got, {m_tlast, m_tdata}, exp_w); end
                end
                got++;
            end
            stall_prev = m_tvalid && !m_tready;
            held = {m_tlast, m_tdata};
            tick();
            cyc++;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            m_tready = lfsr[0] | lfsr[3];
            s_tvalid = (sent < 400);
            s_tdata = sent[7:0];
            s_tlast = (sent % 4 == 3);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        #1;
        vectors++;
        if (got != 400) begin miscompares++; $display("FAIL b2b_timeout got %0d words want 400", got); end
        vectors++;
        if (level_o !== 5'd0 || m_tvalid !== 1'b0)
            begin miscompares++; $display("FAIL b2b_end got lvl=%0d v=%b want lvl=0 v=0", level_o, m_tvalid); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'h01 + i[7:0]; s_tlast = 1'b0;
            tick();
        end
        s_tvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || level_o !== 5'd0)
            begin miscompares++; $display("FAIL midrst_state got v=%b lvl=%0d want v=0 lvl=0", m_tvalid, level_o); end
        m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        #1;
        vectors++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5 || m_tlast !== 1'b1 || level_o !== 5'd1)
            begin miscompares++; $display("FAIL midrst_word got v=%b d=%h l=%b lvl=%0d want v=1 d=a5 l=1 lvl=1", m_tvalid, m_tdata, m_tlast, level_o); end
        tick();
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || level_o !== 5'd0)
            begin miscompares++; $display("FAIL midrst_alone got v=%b lvl=%0d want v=0 lvl=0", m_tvalid, level_o); end
        m_tready = 1'b0;
    endtask

`ifdef AXIS_PFIFO_DROP_EN
    task automatic test_drop_overflow();
        int drops;
        do_reset();
        m_tready = 1'b0; drops = 0;
        for (int i = 0; i < 15; i++) begin
            s_tvalid = 1'b1; s_tdata = i[7:0]; s_tlast = 1'b1;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'hB0 + i[7:0]; s_tlast = (i == 3);
            #1;
            vectors++;
            if (drop_o !== (i == 3) || s_tready !== 1'b1)
                begin miscompares++; $display("FAIL drop_pulse word %0d got drop=%b rdy=%b want drop=%b rdy=1", i, drop_o, s_tready, (i == 3)); end
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        #1;
        vectors++;
        if (level_o !== 5'd15 || drop_o !== 1'b0)
            begin miscompares++; $display("FAIL drop_level got lvl=%0d drop=%b want lvl=15 drop=0", level_o, drop_o); end
        m_tready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            vectors++;
            if (m_tvalid !== 1'b1 || m_tdata !== i[7:0])
                begin miscompares++; $display("FAIL drop_readout word %0d got v=%b d=%h want v=1 d=%h", i, m_tvalid, m_tdata, i[7:0]); end
            tick();
        end
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || level_o !== 5'd0)
            begin miscompares++; $display("FAIL drop_empty got v=%b lvl=%0d want v=0 lvl=0", m_tvalid, level_o); end
        m_tready = 1'b0;
    endtask

    task automatic test_drop_long_frame();
        int drops, valids;
        do_reset();
        m_tready = 1'b1; drops = 0; valids = 0;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'hC0 + i[7:0]; s_tlast = (i == 19);
            #1;
            if (drop_o === 1'b1) drops++;
            if (m_tvalid !== 1'b0) valids++;
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        repeat (3) begin
            #1;
            if (m_tvalid !== 1'b0) valids++;
            if (drop_o === 1'b1) drops++;
            tick();
        end
        vectors++;
        if (drops != 1) begin miscompares++; $display("FAIL long_drop_count got %0d want 1", drops); end
        vectors++;
        if (valids != 0) begin miscompares++; $display("FAIL long_m_tvalid got %0d cycles high want 0", valids); end
        vectors++;
        if (level_o !== 5'd0) begin miscompares++; $display("FAIL long_level got %0d want 0", level_o); end
        m_tready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_full();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef AXIS_PFIFO_DROP_EN
        test_drop_overflow();
        test_drop_long_frame();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
